blackjack_top: RTL and testbench

//  Top level of a single-player blackjack game. Player (HIT/STAND) plays against an automatic dealer.

---
 rtl/blackjack_top.sv | 203 ++++++++++++++++++++
 tb/tb_blackjack_top.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_top.sv
// Single-player blackjack against an automatic dealer. Cards come from a free-running LFSR;
// hand totals and game state drive a 16-bit LED word and a 4-digit multiplexed 7-seg display.
module blackjack_top #(
  parameter int          REFRESH_BITS = 10,
  parameter int          DEALER_STAND = 17,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        HIT,
  input  logic        STAND,
  input  logic        SW,
  output logic [6:0]  SSEG,
  output logic [3:0]  DISP,
  output logic [15:0] LED
);
  typedef enum logic [3:0] {
    S_IDLE, S_DEAL0, S_DEAL1, S_DEAL2, S_DEAL3, S_PLAYER, S_DEALER, S_DONE
  } state_t;
  typedef struct packed { logic [5:0] hard; logic ace; } hand_t;

  localparam logic [5:0] STAND_LVL = 6'(DEALER_STAND);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_D     = 7'b0100001;

  state_t                  state_q;
  hand_t                   p_q, d_q;
  logic [2:0]              result_q;  // {push, lose, win}
  logic [2:0]              hit_s_q, stand_s_q, sw_s_q;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic                    view_q;
  logic                    hit_pulse, stand_pulse, sw_pulse;
  logic [3:0]              rnd, rank;
  logic [5:0]              card_val, p_eff, d_eff;
  logic                    card_ace;
  logic [4:0]              p_sat, d_sat, sel, units, tens;
  logic [1:0]              idx;
  logic [6:0]              digit_seg;

  function automatic logic [5:0] eff_f(input hand_t h);
    return (h.ace && h.hard <= 6'd11) ? h.hard + 6'd10 : h.hard;
  endfunction

  function automatic logic [4:0] sat_f(input logic [5:0] e);
    return (e > 6'd31) ? 5'd31 : e[4:0];
  endfunction

  function automatic logic [6:0] seg_f(input logic [4:0] v);
    case (v)
      5'd0:  return 7'b1000000;
      5'd1:  return 7'b1111001;
      5'd2:  return 7'b0100100;
      5'd3:  return 7'b0110000;
      5'd4:  return 7'b0011001;
      5'd5:  return 7'b0010010;
      5'd6:  return 7'b0000010;
      5'd7:  return 7'b1111000;
      5'd8:  return 7'b0000000;
      5'd9:  return 7'b0010000;
      5'd10: return 7'b0001000;
      5'd11: return 7'b0000011;
      5'd12: return 7'b1000110;
      5'd13: return 7'b0100001;
      5'd14: return 7'b0000110;
      5'd15: return 7'b0001110;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Bit 0 of each pipe is the first sync flop; bit 2 holds the previous synced level.
  assign hit_pulse   = hit_s_q[1] & ~hit_s_q[2];
  assign stand_pulse = stand_s_q[1] & ~stand_s_q[2];
  assign sw_pulse    = sw_s_q[1] & ~sw_s_q[2];

  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign rnd      = lfsr_q[3:0];
  assign rank     = (rnd < 4'd13) ? rnd + 4'd1 : rnd - 4'd12;
  assign card_val = (rank > 4'd10) ? 6'd10 : {2'b00, rank};
  assign card_ace = (rank == 4'd1);

  assign p_eff = eff_f(p_q);
  assign d_eff = eff_f(d_q);
  assign p_sat = sat_f(p_eff);
  assign d_sat = sat_f(d_eff);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_s_q   <= '0;
      stand_s_q <= '0;
      sw_s_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      cnt_q     <= '0;
      view_q    <= 1'b0;
    end else begin
      hit_s_q   <= {hit_s_q[1:0], HIT};
      stand_s_q <= {stand_s_q[1:0], STAND};
      sw_s_q    <= {sw_s_q[1:0], SW};
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_q + 1'b1;
      if (sw_pulse) view_q <= ~view_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      d_q      <= '0;
      result_q <= '0;
    end else if (EN) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      d_q      <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          p_q      <= '0;
          d_q      <= '0;
          result_q <= '0;
          state_q  <= S_DEAL0;
        end
        S_DEAL0: begin
          p_q     <= '{hard: p_q.hard + card_val, ace: p_q.ace | card_ace};
          state_q <= S_DEAL1;
        end
        S_DEAL1: begin
          d_q     <= '{hard: d_q.hard + card_val, ace: d_q.ace | card_ace};
          state_q <= S_DEAL2;
        end
        S_DEAL2: begin
          p_q     <= '{hard: p_q.hard + card_val, ace: p_q.ace | card_ace};
          state_q <= S_DEAL3;
        end
        S_DEAL3: begin
          d_q     <= '{hard: d_q.hard + card_val, ace: d_q.ace | card_ace};
          state_q <= S_PLAYER;
        end
        S_PLAYER: begin
          // Bust is judged on the registered hand, one cycle after the card lands.
          if (p_eff > 6'd21) begin
            result_q <= 3'b010;
            state_q  <= S_DONE;
          end else if (stand_pulse) begin
            state_q <= S_DEALER;
          end else if (hit_pulse) begin
            p_q <= '{hard: p_q.hard + card_val, ace: p_q.ace | card_ace};
          end
        end
        S_DEALER: begin
          if (d_eff < STAND_LVL) begin
            d_q <= '{hard: d_q.hard + card_val, ace: d_q.ace | card_ace};
          end else begin
            state_q <= S_DONE;
            if (d_eff > 6'd21)      result_q <= 3'b001;
            else if (p_eff > d_eff) result_q <= 3'b001;
            else if (p_eff < d_eff) result_q <= 3'b010;
            else                    result_q <= 3'b100;
          end
        end
        S_DONE: begin
          if (hit_pulse) begin
            p_q      <= '0;
            d_q      <= '0;
            result_q <= '0;
            state_q  <= S_DEAL0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign idx   = cnt_q[REFRESH_BITS-1 -: 2];
  assign sel   = view_q ? d_sat : p_sat;
  assign units = sel % 5'd10;
  assign tens  = sel / 5'd10;

  always_comb begin
    digit_seg = SEG_BLANK;
    case (idx)
      2'd0:    digit_seg = seg_f(units);
      2'd1:    digit_seg = (tens == 5'd0) ? SEG_BLANK : seg_f(tens);
      2'd2:    digit_seg = SEG_BLANK;
      default: digit_seg = view_q ? SEG_D : SEG_P;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LED  <= 16'h0000;
      DISP <= 4'b1110;
      SSEG <= 7'b1000000;
    end else begin
      LED  <= {result_q, state_q == S_DONE, state_q == S_PLAYER, view_q, d_sat, p_sat};
      DISP <= ~(4'b0001 << idx);
      SSEG <= digit_seg;
    end
  end
endmodule

// File: tb/tb_blackjack_top.sv
// Randomized bench for blackjack_top: a cycle-indexed card table plus rule-level hand model
// predict LED words at each PLAYER/DONE entry; a monitor pops and compares them.
module tb_blackjack_top;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          MAXC    = 20000;
  localparam logic [6:0]  BLANK   = 7'b1111111;
  localparam logic [6:0]  GLYPH_P = 7'b0001100;
  localparam logic [6:0]  GLYPH_D = 7'b0100001;

  logic        CLK   = 1'b0;
  logic        RST   = 1'b1;
  logic        EN    = 1'b1;
  logic        HIT   = 1'b0;
  logic        STAND = 1'b0;
  logic        SW    = 1'b0;
  logic [6:0]  SSEG;
  logic [3:0]  DISP;
  logic [15:0] LED;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [15:0] lf_tab [0:MAXC];
  logic [15:0] exp_q [$];
  logic [6:0]  seg_tab [0:9];
  logic [15:0] led_prev = '0;
  int          p_hard, d_hard;
  bit          p_ace, d_ace, view, bust;

  blackjack_top #(.REFRESH_BITS(10), .DEALER_STAND(17), .LFSR_SEED(SEED)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .HIT(HIT), .STAND(STAND), .SW(SW),
    .SSEG(SSEG), .DISP(DISP), .LED(LED)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // cyc = number of rising edges since reset release; edge n draws from lf_tab[n].
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 40000 cycles");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int card_of(input int n, output bit ace);
    int r, rank;
    r    = int'(lf_tab[n][3:0]);
    rank = (r < 13) ? r + 1 : r - 12;
    ace  = (rank == 1);
    return (rank > 10) ? 10 : rank;
  endfunction

  function automatic int eff(input int hard, input bit ace);
    return (ace && hard <= 11) ? hard + 10 : hard;
  endfunction

  function automatic logic [15:0] led_word(input logic done, input logic player, input logic [2:0] res);
    int pe, de;
    pe = eff(p_hard, p_ace);
    de = eff(d_hard, d_ace);
    if (pe > 31) pe = 31;
    if (de > 31) de = 31;
    return {res, done, player, view, de[4:0], pe[4:0]};
  endfunction

  task automatic add_p(input int n);
    bit a;
    p_hard += card_of(n, a);
    p_ace  |= a;
  endtask

  task automatic add_d(input int n);
    bit a;
    d_hard += card_of(n, a);
    d_ace  |= a;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && ((LED[12] && !led_prev[12]) || (LED[11] && !led_prev[11]))) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_unexpected: LED %h appeared, expected no event", LED);
      end else begin
        check("scoreboard_led", LED, exp_q.pop_front());
      end
    end
    led_prev = LED;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic start_game();
    int c;
    c = cyc;
    EN = 1'b0;
    p_hard = 0; d_hard = 0; p_ace = 0; d_ace = 0;
    add_p(c + 2); add_d(c + 3); add_p(c + 4); add_d(c + 5);
    exp_q.push_back(led_word(1'b0, 1'b1, 3'b000));
    wait_until(c + 7);
  endtask

  task automatic hit_task(input int hold);
    int c;
    c = cyc;
    HIT = 1'b1;
    add_p(c + 3);
    if (eff(p_hard, p_ace) > 21) begin
      bust = 1;
      exp_q.push_back(led_word(1'b1, 1'b0, 3'b010));
    end
    tick(hold);
    HIT = 1'b0;
    tick(4);
    if (!bust) check("hit_one_card", LED, led_word(1'b0, 1'b1, 3'b000));
  endtask

  task automatic stand_task(input bit both);
    int c, n, pe, de;
    logic [2:0] res;
    c = cyc;
    STAND = 1'b1;
    if (both) HIT = 1'b1;
    n = c + 4;
    while (eff(d_hard, d_ace) < 17) begin
      add_d(n);
      n++;
    end
    pe = eff(p_hard, p_ace);
    de = eff(d_hard, d_ace);
    if (de > 21)      res = 3'b001;
    else if (pe > de) res = 3'b001;
    else if (pe < de) res = 3'b010;
    else              res = 3'b100;
    exp_q.push_back(led_word(1'b1, 1'b0, res));
    tick(3);
    STAND = 1'b0;
    HIT   = 1'b0;
    wait_until(n + 4);
  endtask

  task automatic new_round();
    int c;
    c = cyc;
    HIT = 1'b1;
    p_hard = 0; d_hard = 0; p_ace = 0; d_ace = 0;
    add_p(c + 4); add_d(c + 5); add_p(c + 6); add_d(c + 7);
    exp_q.push_back(led_word(1'b0, 1'b1, 3'b000));
    tick(2);
    HIT = 1'b0;
    wait_until(c + 9);
  endtask

  task automatic play_round();
    int nh;
    tick($urandom_range(0, 7));
    nh   = $urandom_range(0, 3);
    bust = 0;
    for (int i = 0; i < nh && !bust; i++) begin
      hit_task($urandom_range(1, 50));
      tick($urandom_range(0, 5));
    end
    if (!bust) stand_task($urandom_range(0, 3) == 0);
    new_round();
  endtask

  task automatic sw_toggle();
    SW   = 1'b1;
    view = ~view;
    tick(2);
    SW = 1'b0;
    tick(4);
    check("view_led", LED, led_word(1'b0, 1'b1, 3'b000));
  endtask

  task automatic display_scan();
    bit [3:0]   seen;
    int         v;
    logic [6:0] e;
    seen = '0;
    v = view ? eff(d_hard, d_ace) : eff(p_hard, p_ace);
    if (v > 31) v = 31;
    for (int i = 0; i < 1100 && seen != 4'hF; i++) begin
      @(negedge CLK);
      for (int k = 0; k < 4; k++) begin
        if (DISP == ~(4'b0001 << k) && !seen[k]) begin
          seen[k] = 1'b1;
          case (k)
            0:       e = seg_tab[v % 10];
            1:       e = (v / 10 == 0) ? BLANK : seg_tab[v / 10];
            2:       e = BLANK;
            default: e = view ? GLYPH_D : GLYPH_P;
          endcase
          check($sformatf("digit%0d_view%0d", k, view), {9'b0, SSEG}, {9'b0, e});
        end
      end
    end
    tests++;
    if (seen != 4'hF) begin
      fails++;
      $display("FAIL display_scan: digits seen %b, expected 1111", seen);
    end
    tick(1);
  endtask

  task automatic en_test();
    EN = 1'b1;
    tick(3);
    check("en_idle_led", LED, {5'b00000, view, 10'b0});
  endtask

  task automatic rst_mid_dealer();
    STAND = 1'b1;
    tick(3);
    RST = 1'b1;
    #1;
    check("rst_led", LED, 16'h0000);
    check("rst_disp", {12'b0, DISP}, 16'h000E);
    check("rst_sseg", {9'b0, SSEG}, 16'h0040);
    STAND = 1'b0;
    EN    = 1'b1;
    view  = 0;
    tick(2);
    RST = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    lf_tab[0] = SEED;
    lf_tab[1] = SEED;
    for (int n = 1; n < MAXC; n++) lf_tab[n + 1] = {lf_tab[n][14:0], ^(lf_tab[n] & 16'hB400)};
    view = 0;

    tick(3);
    check("reset_led", LED, 16'h0000);
    check("reset_disp", {12'b0, DISP}, 16'h000E);
    check("reset_sseg", {9'b0, SSEG}, 16'h0040);
    RST = 1'b0;
    start_game();

    sw_toggle();
    display_scan();
    sw_toggle();
    display_scan();

    for (int r = 0; r < 10; r++) play_round();

    en_test();
    start_game();
    play_round();

    rst_mid_dealer();
    start_game();
    for (int r = 0; r < 4; r++) play_round();

    tick(5);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected events pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
